cpu_trace_emitter: RTL and testbench

Serialises one structured CPU write-back event per transaction into the ASCII trace-line format consumed by `cpu_checker`, emitting one character per clock. It sits between the CPU model's retire stage and the trace sink (checker, UART, or log), and acts as the transmit end of the trace-character stream. Output is always canonical: a single space wherever the format allows whitespace, and leading zeros suppressed in decimal fields.

---
 rtl/cpu_trace_pkg.sv | 74 +++++++
 rtl/trace_bin2bcd.sv | 41 ++++
 rtl/cpu_trace_emitter.sv | 176 +++++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared constants, event encodings and FSM states for the CPU trace-line format.
// Latency: n/a (package only).
// Backpressure: n/a. CPU_TRACE_UPPER_HEX_EN selects uppercase hex letters in hex_char().
package cpu_trace_pkg;

    // ASCII punctuation used by the trace-line grammar
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_ZERO   = 8'h30;

`ifdef CPU_TRACE_UPPER_HEX_EN
    localparam logic [7:0] CH_HEX_A  = 8'h41;
`else
    localparam logic [7:0] CH_HEX_A  = 8'h61;
`endif

    // Event type encodings (0 and 3 are dropped)
    localparam logic [1:0] TRACE_NONE = 2'd0;
    localparam logic [1:0] TRACE_REG  = 2'd1;
    localparam logic [1:0] TRACE_MEM  = 2'd2;

    // Largest printable timestamp; larger values saturate at capture
    localparam logic [13:0] TIME_MAX = 14'd9999;

    // One state per emitted field; the three separating spaces get distinct states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CARET,
        ST_TIME,
        ST_AT,
        ST_PC,
        ST_COLON,
        ST_SP_A,
        ST_TAG,
        ST_DEST,
        ST_SP_B,
        ST_LT,
        ST_EQ,
        ST_SP_C,
        ST_DATA,
        ST_HASH
    } trace_state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] n8;
        n8 = {4'h0, nib};
        if (nib < 4'd10) begin
            return CH_ZERO + n8;
        end
        return CH_HEX_A + n8 - 8'd10;
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] digit);
        return CH_ZERO + {4'h0, digit};
    endfunction

    // Picks one BCD digit; idx 0 is the ones digit
    function automatic logic [3:0] bcd_digit(input logic [15:0] bcd, input logic [1:0] idx);
        case (idx)
            2'd0:    return bcd[3:0];
            2'd1:    return bcd[7:4];
            2'd2:    return bcd[11:8];
            default: return bcd[15:12];
        endcase
    endfunction

endpackage

// File: rtl/trace_bin2bcd.sv
// Combinational double-dabble: 14-bit binary (caller keeps it <= 9999) to 4 BCD digits + digit count.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module trace_bin2bcd
    import cpu_trace_pkg::*;
(
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic [2:0]  ndig
);

    logic [15:0] acc;

    // Shift-and-add-3 conversion; a thousands overflow cannot occur for inputs up to TIME_MAX
    always_comb begin
        acc = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (acc[d*4 +: 4] >= 4'd5) begin
                    acc[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
                end
            end
            acc = {acc[14:0], bin[i]};
        end
        bcd = acc;
    end

    // Number of significant digits; zero still prints one digit
    always_comb begin
        if (bcd_digit(acc, 2'd3) != 4'd0) begin
            ndig = 3'd4;
        end else if (bcd_digit(acc, 2'd2) != 4'd0) begin
            ndig = 3'd3;
        end else if (bcd_digit(acc, 2'd1) != 4'd0) begin
            ndig = 3'd2;
        end else begin
            ndig = 3'd1;
        end
    end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one CPU write-back event into an ASCII trace line, one character per clock.
// Latency: first char ('^') is registered out the cycle after accept; no gaps until '#'.
// Backpressure: in_ready only in IDLE and on the '#' cycle; CPU_TRACE_UPPER_HEX_EN selects uppercase hex.
module cpu_trace_emitter
    import cpu_trace_pkg::*;
#(
    parameter int TIME_W = 14   // must be >= 14 so the saturation limit is representable
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [TIME_W-1:0] in_time,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_reg,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    output logic [7:0]        char,
    output logic              char_valid,
    output logic              busy
);

    trace_state_e state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [1:0]   type_q, type_d;
    logic [13:0]  time_q, time_d;
    logic [31:0]  pc_q, pc_d;
    logic [4:0]   reg_q, reg_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  data_q, data_d;
    logic [7:0]   char_q, char_d;
    logic         char_valid_q, char_valid_d;
    logic         in_ready_q, in_ready_d;

    logic         accept;
    logic         type_ok;
    logic [13:0]  time_sat;
    logic [15:0]  time_bcd;
    logic [2:0]   time_ndig;
    logic [15:0]  reg_bcd;
    logic [2:0]   reg_ndig;

    assign accept     = in_valid && in_ready_q;
    assign type_ok    = (in_type == TRACE_REG) || (in_type == TRACE_MEM);
    assign in_ready   = in_ready_q;
    assign char       = char_q;
    assign char_valid = char_valid_q;
    assign busy       = char_valid_q;

    // Clamp the timestamp before capture so the decimal field never exceeds four digits
    always_comb begin
        if (in_time > TIME_W'(TIME_MAX)) begin
            time_sat = TIME_MAX;
        end else begin
            time_sat = 14'(in_time);
        end
    end

    trace_bin2bcd u_time_bcd (
        .bin  (time_q),
        .bcd  (time_bcd),
        .ndig (time_ndig)
    );

    trace_bin2bcd u_reg_bcd (
        .bin  ({9'd0, reg_q}),
        .bcd  (reg_bcd),
        .ndig (reg_ndig)
    );

    // Next state, digit counter, field capture and the registered character for the next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        time_d  = time_q;
        pc_d    = pc_q;
        reg_d   = reg_q;
        addr_d  = addr_q;
        data_d  = data_q;

        if (accept) begin
            type_d = in_type;
            time_d = time_sat;
            pc_d   = in_pc;
            reg_d  = in_reg;
            addr_d = in_addr;
            data_d = in_data;
        end

        case (state_q)
            ST_IDLE:  if (accept && type_ok) state_d = ST_CARET;
            ST_CARET: begin
                state_d = ST_TIME;
                cnt_d   = time_ndig - 3'd1;
            end
            ST_TIME:  if (cnt_q == 3'd0) state_d = ST_AT; else cnt_d = cnt_q - 3'd1;
            ST_AT: begin
                state_d = ST_PC;
                cnt_d   = 3'd7;
            end
            ST_PC:    if (cnt_q == 3'd0) state_d = ST_COLON; else cnt_d = cnt_q - 3'd1;
            ST_COLON: state_d = ST_SP_A;
            ST_SP_A:  state_d = ST_TAG;
            ST_TAG: begin
                state_d = ST_DEST;
                cnt_d   = (type_q == TRACE_REG) ? (reg_ndig - 3'd1) : 3'd7;
            end
            ST_DEST:  if (cnt_q == 3'd0) state_d = ST_SP_B; else cnt_d = cnt_q - 3'd1;
            ST_SP_B:  state_d = ST_LT;
            ST_LT:    state_d = ST_EQ;
            ST_EQ:    state_d = ST_SP_C;
            ST_SP_C: begin
                state_d = ST_DATA;
                cnt_d   = 3'd7;
            end
            ST_DATA:  if (cnt_q == 3'd0) state_d = ST_HASH; else cnt_d = cnt_q - 3'd1;
            ST_HASH:  state_d = (accept && type_ok) ? ST_CARET : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        char_valid_d = (state_d != ST_IDLE);
        in_ready_d   = (state_d == ST_IDLE) || (state_d == ST_HASH);

        case (state_d)
            ST_CARET: char_d = CH_CARET;
            ST_TIME:  char_d = dec_char(bcd_digit(time_bcd, cnt_d[1:0]));
            ST_AT:    char_d = CH_AT;
            ST_PC:    char_d = hex_char(pc_q[{cnt_d, 2'b00} +: 4]);
            ST_COLON: char_d = CH_COLON;
            ST_SP_A,
            ST_SP_B,
            ST_SP_C:  char_d = CH_SPACE;
            ST_TAG:   char_d = (type_q == TRACE_REG) ? CH_DOLLAR : CH_STAR;
            ST_DEST:  char_d = (type_q == TRACE_REG) ? dec_char(bcd_digit(reg_bcd, cnt_d[1:0]))
                                                     : hex_char(addr_q[{cnt_d, 2'b00} +: 4]);
            ST_LT:    char_d = CH_LT;
            ST_EQ:    char_d = CH_EQ;
            ST_DATA:  char_d = hex_char(data_q[{cnt_d, 2'b00} +: 4]);
            ST_HASH:  char_d = CH_HASH;
            default:  char_d = 8'h00;
        endcase
    end

    // All state and outputs registered; reset aborts any record in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            type_q       <= TRACE_NONE;
            time_q       <= 14'd0;
            pc_q         <= 32'd0;
            reg_q        <= 5'd0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
            char_q       <= 8'h00;
            char_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            type_q       <= type_d;
            time_q       <= time_d;
            pc_q         <= pc_d;
            reg_q        <= reg_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            char_q       <= char_d;
            char_valid_q <= char_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Randomised scoreboard bench: the driver formats each accepted event into a string and queues its
// characters; the monitor pops one character per valid cycle and checks char/char_valid/busy/in_ready.
// An empty queue means the line must be idle; a non-empty queue means characters are due with no gaps.
module tb_cpu_trace_emitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [13:0] in_time;
    logic [31:0] in_pc;
    logic [4:0]  in_reg;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [7:0]  char;
    logic        char_valid;
    logic        busy;

    logic [7:0]  exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic        rst_at_edge = 1'b1;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    cpu_trace_emitter #(.TIME_W(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_time    (in_time),
        .in_pc      (in_pc),
        .in_reg     (in_reg),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .char       (char),
        .char_valid (char_valid),
        .busy       (busy)
    );

    always @(posedge clk) rst_at_edge <= reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string hx(input logic [31:0] v);
        string s;
        s = $sformatf("%08h", v);
`ifdef CPU_TRACE_UPPER_HEX_EN
        s = s.toupper();
`endif
        return s;
    endfunction

    // Reference formatting of a record straight from the trace-line grammar
    function automatic string fmt_rec(input logic [1:0] ty, input logic [13:0] tm, input logic [31:0] pc,
                                      input logic [4:0] rg, input logic [31:0] ad, input logic [31:0] dt);
        int t;
        t = (int'(tm) > 9999) ? 9999 : int'(tm);
        if (ty == 2'd1) return $sformatf("^%0d@%s: $%0d <= %s#", t, hx(pc), rg, hx(dt));
        return $sformatf("^%0d@%s: *%s <= %s#", t, hx(pc), hx(ad), hx(dt));
    endfunction

    // Monitor: one check set per cycle, sampled on the falling edge
    always @(negedge clk) begin
        logic       exp_rdy;
        logic [7:0] e;
        if (mon_en) begin
            exp_rdy = !rst_at_edge && ((exp_q.size() == 0) || (exp_q[0] == 8'h23));
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("char_valid", {31'd0, char_valid}, 32'd1);
                chk("busy", {31'd0, busy}, 32'd1);
                chk("char", {24'd0, char}, {24'd0, e});
            end else begin
                chk("idle_valid", {31'd0, char_valid}, 32'd0);
                chk("idle_busy", {31'd0, busy}, 32'd0);
                chk("idle_char", {24'd0, char}, 32'd0);
            end
        end
    end

    // Present one event, wait for the handshake, then queue its expected characters
    task automatic send(input logic [1:0] ty, input logic [13:0] tm, input logic [31:0] pc,
                        input logic [4:0] rg, input logic [31:0] ad, input logic [31:0] dt);
        bit    ok;
        string s;
        in_valid = 1'b1;
        in_type  = ty;
        in_time  = tm;
        in_pc    = pc;
        in_reg   = rg;
        in_addr  = ad;
        in_data  = dt;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout: got=no_ready exp=ready at %0t", $time);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (ty == 2'd1 || ty == 2'd2) begin
            s = fmt_rec(ty, tm, pc, rg, ad, dt);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        end
        // Scramble inputs to prove the fields were captured at accept
        in_valid = 1'b0;
        in_type  = 2'($urandom);
        in_time  = 14'($urandom);
        in_pc    = $urandom;
        in_reg   = 5'($urandom);
        in_addr  = $urandom;
        in_data  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [13:0] tm;
        bit          drained;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_type  = 2'd0;
        in_time  = 14'd0;
        in_pc    = 32'd0;
        in_reg   = 5'd0;
        in_addr  = 32'd0;
        in_data  = 32'd0;
        idle(2);
        mon_en = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);

        // Directed records from the reference examples
        send(2'd1, 14'd242, 32'h000030f4, 5'd31, 32'h0, 32'h12345678);
        idle(3);
        send(2'd2, 14'd338, 32'h00003130, 32'h00000088, 32'h0fffb528, 32'h0fffb528);
        idle(40);
        // Back-to-back: the second is accepted on the '#' cycle
        send(2'd1, 14'd7, 32'hdeadbeef, 5'd5, 32'h0, 32'hcafef00d);
        send(2'd2, 14'd1234, 32'h00000010, 5'd0, 32'habcdef01, 32'h00000000);
        idle(2);
        // Boundaries: zero time/reg, saturated time, dropped types, hex letters
        send(2'd1, 14'd0, 32'h00000000, 5'd0, 32'h0, 32'h00000001);
        send(2'd1, 14'd12000, 32'h00001000, 5'd9, 32'h0, 32'h89abcdef);
        send(2'd0, 14'd55, 32'h11111111, 5'd3, 32'h1, 32'h2);
        send(2'd3, 14'd66, 32'h22222222, 5'd4, 32'h3, 32'h4);
        idle(4);
        send(2'd2, 14'd9999, 32'hffffffff, 5'd0, 32'hfffb528b, 32'hfffb528b);
        idle(40);

        // Reset on the 10th character aborts the record; a fresh record follows cleanly
        send(2'd1, 14'd100, 32'h0a0b0c0d, 5'd17, 32'h0, 32'h55aa55aa);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        idle(1);
        reset = 1'b0;
        idle(1);
        send(2'd2, 14'd42, 32'h00c0ffee, 5'd0, 32'h00000044, 32'hbadc0de5);

        // Random traffic with random gaps and occasional dropped types
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0:       tm = 14'($urandom_range(0, 9));
                1:       tm = 14'($urandom_range(10, 99));
                2:       tm = 14'($urandom_range(100, 999));
                3:       tm = 14'($urandom_range(1000, 9999));
                default: tm = 14'($urandom_range(10000, 16383));
            endcase
            send(2'($urandom_range(0, 3)), tm, $urandom, 5'($urandom_range(0, 31)), $urandom, $urandom);
            idle($urandom_range(0, 2));
        end

        drained = 1'b0;
        for (int n = 0; n < 300 && !drained; n++) begin
            @(posedge clk);
            drained = (exp_q.size() == 0);
        end
        total++;
        if (!drained) begin
            bad++;
            $display("FAIL drain_timeout: got=%0d chars pending exp=0", exp_q.size());
        end
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
